// File: rtl/data_mem_ctrl.sv
// Load/store controller between the ALU and the data-memory bus: lane steering,
// load extension, alignment checking, request/grant sequencing and bus timeout.
module data_mem_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                  CLK,
  input  logic                  RST_n,
  input  logic [DATA_WIDTH-1:0] ALUResult,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [2:0]            Funct3,
  output logic [DATA_WIDTH-1:0] ReadData,
  output logic                  Stall,
  output logic                  MisalignErr,
  output logic                  BusErr,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            armed_q, armed_d;
  logic            req_q, req_d;
  logic            we_q, we_d;
  logic [31:0]     addr_q, addr_d;
  logic [3:0]      be_q, be_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [2:0]      f3_q, f3_d;
  logic [1:0]      off_q, off_d;
  logic [31:0]     read_data_q, read_data_d;
  logic            misalign_q, misalign_d;
  logic            bus_err_q, bus_err_d;

  logic            access, legal, start, misalign_evt;
  logic [3:0]      be_new;
  logic [31:0]     wdata_new, shifted, load_data;

  assign access = MemRead | MemWrite;

  always_comb begin
    unique case (Funct3)
      3'b000, 3'b100: legal = 1'b1;
      3'b001, 3'b101: legal = ~ALUResult[0];
      3'b010:         legal = (ALUResult[1:0] == 2'b00);
      default:        legal = 1'b0;
    endcase
  end

  // Gating with RST_n keeps Stall at its reset value while reset is held,
  // even if the core is still presenting an access.
  assign start        = RST_n & (state_q == IDLE) & access & legal & armed_q;
  assign misalign_evt = (state_q == IDLE) & access & ~legal & armed_q;
  assign Stall        = start | (state_q == REQ) | (state_q == WAIT_R);

  always_comb begin
    unique case (Funct3[1:0])
      2'b00: begin
        be_new    = 4'b0001 << ALUResult[1:0];
        wdata_new = {4{WriteData[7:0]}};
      end
      2'b01: begin
        be_new    = 4'b0011 << ALUResult[1:0];
        wdata_new = {2{WriteData[15:0]}};
      end
      default: begin
        be_new    = 4'b1111;
        wdata_new = WriteData;
      end
    endcase
  end

  assign shifted = mem_rdata >> {off_q, 3'b000};

  always_comb begin
    unique case (f3_q)
      3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_data = {24'h0, shifted[7:0]};
      3'b101:  load_data = {16'h0, shifted[15:0]};
      default: load_data = mem_rdata;
    endcase
  end

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned,
    // which would otherwise infer a latch.
    state_d     = state_q;
    cnt_d       = '0;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    f3_d        = f3_q;
    off_d       = off_q;
    read_data_d = read_data_q;
    bus_err_d   = 1'b0;
    misalign_d  = misalign_evt;
    armed_d     = access ? (armed_q & ~misalign_evt) : 1'b1;

    unique case (state_q)
      IDLE: if (start) begin
        state_d = REQ;
        req_d   = 1'b1;
        we_d    = MemWrite;
        addr_d  = {ALUResult[31:2], 2'b00};
        be_d    = be_new;
        wdata_d = wdata_new;
        f3_d    = Funct3;
        off_d   = ALUResult[1:0];
      end
      REQ: begin
        cnt_d = cnt_q + 1'b1;
        if (mem_gnt) begin
          req_d   = 1'b0;
          state_d = we_q ? DONE : WAIT_R;
        end else if (cnt_q == CNT_MAX) begin
          req_d       = 1'b0;
          state_d     = DONE;
          bus_err_d   = 1'b1;
          read_data_d = '0;
        end
      end
      WAIT_R: begin
        cnt_d = cnt_q + 1'b1;
        if (mem_rvalid) begin
          read_data_d = load_data;
          state_d     = DONE;
        end else if (cnt_q == CNT_MAX) begin
          state_d     = DONE;
          bus_err_d   = 1'b1;
          read_data_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      armed_q     <= 1'b1;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      be_q        <= '0;
      wdata_q     <= '0;
      f3_q        <= '0;
      off_q       <= '0;
      read_data_q <= '0;
      misalign_q  <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      armed_q     <= armed_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      f3_q        <= f3_d;
      off_q       <= off_d;
      read_data_q <= read_data_d;
      misalign_q  <= misalign_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign ReadData    = read_data_q;
  assign MisalignErr = misalign_q;
  assign BusErr      = bus_err_q;
  assign mem_req     = req_q;
  assign mem_we      = we_q;
  assign mem_addr    = addr_q;
  assign mem_be      = be_q;
  assign mem_wdata   = wdata_q;

endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Load/store access controller sitting directly downstream of the ALU in the RISC-V core: it takes the ALU result as the effective address, converts a core load/store into a request/grant transaction on the data-memory bus, and stalls the core until the access completes. It performs byte-lane steering, sign/zero extension, alignment checking and a bus timeout. Loads return data to the writeback mux; stores complete once the memory grants them.

## Interface
- DATA_WIDTH, 32: data and address width; only 32 is supported.
- TIMEOUT, 16: cycles spent waiting in REQ or WAIT_R before a bus error; must be at least 2.
- CLK  in  1  clock; all state changes on the rising edge.
- RST_n  in  1  reset, asynchronous and active-low.
- ALUResult  in  32  effective byte address.
- WriteData  in  32  store data, right-aligned.
- MemRead  in  1  load request, level, held by the core while Stall is high.
- MemWrite  in  1  store request, level; wins if asserted together with MemRead.
- Funct3  in  3  access size: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- ReadData  out  32  extended load result.
- Stall  out  1  freezes the PC and pipeline registers.
- MisalignErr  out  1  one-cycle pulse: misaligned address or illegal Funct3.
- BusErr  out  1  one-cycle pulse: timeout expired.
- mem_req  out  1  bus request.
- mem_we  out  1  1 = write.
- mem_addr  out  32  word address, {addr[31:2],2'b00}.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-replicated store data.
- mem_gnt  in  1  request accepted in this cycle.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  32  read data.

## Operation
- FSM states are IDLE, REQ, WAIT_R and DONE. Reset state is IDLE.
- **IDLE:**
  - When an access is present (MemRead or MemWrite) and it is legal, latch the address, the write data with byte enables, we, Funct3 and offset, then go to REQ. Stall is asserted combinationally in this same cycle.
  - When the access is illegal, issue no bus request and keep Stall at 0. Register MisalignErr so it is 1 in the next cycle. The FSM stays in IDLE; it re-checks only after MemRead and MemWrite have dropped (edge-armed flag).
- **Illegal access:** h/hu with addr[0]=1; w with addr[1:0]≠0; Funct3 of 011, 110 or 111.
- **REQ:**
  - mem_req=1 with stable latched outputs.
  - On mem_gnt: a write goes to DONE, a read goes to WAIT_R.
- **WAIT_R:** on mem_rvalid, register the extracted data and go to DONE.
- **DONE:** Stall=0 and ReadData is valid. The next state is always IDLE, so the still-asserted request does not re-trigger.
- **Timeout:**
  - A counter is cleared on entry to REQ and counts every cycle in REQ and WAIT_R.
  - When it reaches TIMEOUT-1 with no gnt or rvalid: go to DONE, pulse BusErr during DONE, set ReadData=0 and drop mem_req.
- **Store lanes:**
  - b: be=0001<<off, wdata = byte replicated ×4.
  - h: be=0011<<off, wdata = halfword replicated ×2.
  - w: be=1111.
- **Load extraction:**
  - Shift mem_rdata right by 8·off.
  - b/h are sign-extended from bit 7/15; bu/hu are zero-extended; w is passed through.
- **Priority:** when MemRead and MemWrite are both 1, the access is a write.

## Timing
- **Reset values:** ReadData=0, Stall=0, MisalignErr=0, BusErr=0, mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0, FSM=IDLE, timeout counter=0.
- **Reset mid-transaction:** all outputs return to the reset values immediately (asynchronous) and any transaction in flight is abandoned.
- **Best-case load:**
  - Cycle 0: IDLE, Stall=1.
  - Cycle 1: REQ with gnt.
  - Cycle 2: WAIT_R with rvalid.
  - Cycle 3: DONE, Stall=0.
  - Total: 3 stall cycles.
- **Best-case store:** cycle 0 IDLE, cycle 1 REQ with gnt, cycle 2 DONE. Total: 2 stall cycles.
- **Bus rules:**
  - mem_req stays high until the gnt cycle inclusive and deasserts the cycle after.
  - Address, be and wdata must not change while mem_req=1.
  - rvalid arriving in the gnt cycle is ignored; rvalid is only sampled in WAIT_R.
- **Back-to-back:** consecutive memory instructions each restart from IDLE, giving a minimum spacing of one non-stalled cycle (DONE).

## Test plan
- **lw:** addr 0x100, gnt in first REQ cycle, rdata 0xDEADBEEF one cycle later -> Stall high for 3 cycles, ReadData=0xDEADBEEF in DONE, mem_be=1111.
- **lb/lbu:** addr 0x103, rdata 0x80FF_0000 -> lb gives 0xFFFFFF80 and lbu gives 0x00000080. lh at 0x102 gives 0xFFFF80FF.
- **sb:** addr 0x0002, WriteData 0x12345678 -> mem_be=0100, mem_wdata=0x78787878, mem_addr=0x0. Stall held 2 cycles when gnt is immediate.
- **sh at 0x101 and lw at 0x102:** -> no mem_req, MisalignErr pulses exactly 1 cycle, Stall stays 0.
- **No grant:** gnt held low with TIMEOUT=16 -> mem_req high for 16 cycles, BusErr pulses once in DONE, ReadData=0, FSM returns to IDLE.
- **Mid-wait reset:** RST_n pulsed low while in WAIT_R -> Stall and mem_req drop asynchronously. After release, a fresh lw completes normally and a stale rvalid is ignored.
